// File: rtl/data_assembler.sv
// data_assembler: packs UART RX bytes into one DATA_WIDTH line, then holds a L2 write until ack.
// Optional partial-line timeout enabled by defining DATA_ASSEMBLER_TIMEOUT_EN.
module data_assembler #(
  parameter int DATA_WIDTH  = 512,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [7:0]                         data_i,
  input  logic                               valid_i,
  output logic [DATA_WIDTH-1:0]              data_o,
  output logic                               write_o,
  input  logic                               ack_i,
  output logic [$clog2(DATA_WIDTH/8)-1:0]    byte_cnt_o,
  output logic                               busy_o,
  output logic                               overflow_o,
  output logic [15:0]                        lines_o,
  output logic                               timeout_o
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int CW        = $clog2(NUM_BYTES);
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    REQ     = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   line_q;
  logic [CW-1:0]           cnt_q;
  logic                    ovf_q;
  logic [15:0]             lines_q;
  logic                    tmo_q;
  logic                    accept;
  logic                    drop;
  logic                    done;
  logic                    tmo_hit;

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  // next state and per-cycle byte/ack decisions
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    drop    = 1'b0;
    done    = 1'b0;
    case (state_q)
      COLLECT: begin
        accept = valid_i;
        if (valid_i && cnt_q == LAST) state_d = REQ;
      end
      REQ: begin
        if (ack_i) begin
          done    = 1'b1;
          accept  = valid_i;
          state_d = COLLECT;
        end else begin
          drop = valid_i;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

`ifdef DATA_ASSEMBLER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] idle_q;
  logic          idle_run;

  assign idle_run = (state_q == COLLECT) && (cnt_q != '0) && !valid_i;
  assign tmo_hit  = idle_run && (idle_q == TW'(TIMEOUT_CYC - 1));

  // idle cycle counter for a stalled partial line
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                   idle_q <= '0;
    else if (!idle_run || tmo_hit) idle_q <= '0;
    else                         idle_q <= idle_q + TW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // line shift register, byte count and status
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      line_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      lines_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      if (accept) begin
        line_q <= {line_q[DATA_WIDTH-9:0], data_i};
        if (state_q == REQ)  cnt_q <= CW'(1);
        else if (cnt_q == LAST) cnt_q <= '0;
        else                 cnt_q <= cnt_q + CW'(1);
      end else if (tmo_hit) begin
        line_q <= '0;
        cnt_q  <= '0;
      end
      if (drop) ovf_q   <= 1'b1;
      if (done) lines_q <= lines_q + 16'd1;
      tmo_q <= tmo_hit;
    end
  end

  assign data_o     = line_q;
  assign write_o    = (state_q == REQ);
  assign busy_o     = (state_q == REQ);
  assign byte_cnt_o = cnt_q;
  assign overflow_o = ovf_q;
  assign lines_o    = lines_q;
  assign timeout_o  = tmo_q;

endmodule

// File: tb/tb_data_assembler.sv
// tb_data_assembler: directed checks of line assembly, write handshake,
// overflow, reset abort and partial-line hold/timeout.
module tb_data_assembler;

  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [7:0]    data_i = 8'h00;
  logic          valid_i = 1'b0;
  logic          ack_i = 1'b0;
  logic [DW-1:0] data_o;
  logic          write_o;
  logic [5:0]    byte_cnt_o;
  logic          busy_o;
  logic          overflow_o;
  logic [15:0]   lines_o;
  logic          timeout_o;

  int            n_pass = 0;
  int            n_total = 0;
  int            tmo_seen = 0;
  logic [DW-1:0] exp_line;
  logic [DW-1:0] held;
  logic          stable;

  data_assembler #(
    .DATA_WIDTH (DW),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .data_o    (data_o),
    .write_o   (write_o),
    .ack_i     (ack_i),
    .byte_cnt_o(byte_cnt_o),
    .busy_o    (busy_o),
    .overflow_o(overflow_o),
    .lines_o   (lines_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (timeout_o) tmo_seen++;

  task automatic check(input string tag,
                       input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    @(negedge clk);
    data_i  = b;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_data"}, data_o, '0);
    check({tag, "_wr"}, DW'(write_o), '0);
    check({tag, "_cnt"}, DW'(byte_cnt_o), '0);
    check({tag, "_busy"}, DW'(busy_o), '0);
    check({tag, "_ovf"}, DW'(overflow_o), '0);
    check({tag, "_lines"}, DW'(lines_o), '0);
    check({tag, "_tmo"}, DW'(timeout_o), '0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset("rst");
    rstn = 1'b1;

    // line 1: 0x00..0x3F, 9 idle cycles apart
    exp_line = '0;
    for (int i = 0; i < 63; i++) begin
      send(8'(i), 9);
      exp_line = {exp_line[DW-9:0], 8'(i)};
    end
    check("l1_cnt63", DW'(byte_cnt_o), DW'(63));
    check("l1_nowr63", DW'(write_o), '0);
    send(8'h3F, 0);
    exp_line = {exp_line[DW-9:0], 8'h3F};
    check("l1_wr", DW'(write_o), DW'(1));
    check("l1_busy", DW'(busy_o), DW'(1));
    check("l1_cnt", DW'(byte_cnt_o), '0);
    check("l1_msb", DW'(data_o[511:504]), DW'(8'h00));
    check("l1_lsb", DW'(data_o[7:0]), DW'(8'h3F));
    check("l1_line", data_o, exp_line);

    // hold REQ 50 cycles, with one dropped byte in the middle
    held   = data_o;
    stable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (c == 25) begin
        data_i  = 8'hAA;
        valid_i = 1'b1;
      end
      @(negedge clk);
      valid_i = 1'b0;
      if (!write_o || data_o !== held) stable = 1'b0;
    end
    check("l1_stable", DW'(stable), DW'(1));
    check("drop_data", data_o, exp_line);
    check("drop_ovf", DW'(overflow_o), DW'(1));
    check("drop_cnt", DW'(byte_cnt_o), '0);
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    check("l1_ack_wr", DW'(write_o), '0);
    check("l1_ack_busy", DW'(busy_o), '0);
    check("l1_lines", DW'(lines_o), DW'(1));

    // line 2 back-to-back, overflow stays sticky
    for (int i = 0; i < 64; i++) begin
      send(8'(i * 3 + 1), 0);
      exp_line = {exp_line[DW-9:0], 8'(i * 3 + 1)};
    end
    check("l2_wr", DW'(write_o), DW'(1));
    check("l2_line", data_o, exp_line);
    check("l2_ovf", DW'(overflow_o), DW'(1));
    @(negedge clk);
    data_i  = 8'h5C;
    valid_i = 1'b1;
    ack_i   = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    ack_i   = 1'b0;
    exp_line = {exp_line[DW-9:0], 8'h5C};
    check("l2_ack_wr", DW'(write_o), '0);
    check("l2_ack_cnt", DW'(byte_cnt_o), DW'(1));
    check("l2_ack_lsb", DW'(data_o[7:0]), DW'(8'h5C));
    check("l2_lines", DW'(lines_o), DW'(2));

    // 20-byte partial line then reset abort
    for (int i = 0; i < 19; i++) send(8'(8'hC0 + i), 0);
    check("p20_cnt", DW'(byte_cnt_o), DW'(20));
    pulse_rst();
    check_reset("rst2");

    // line 3 after reset, closed by simultaneous ack+byte
    exp_line = '0;
    for (int i = 0; i < 64; i++) begin
      send(8'(8'hFF - i), 1);
      exp_line = {exp_line[DW-9:0], 8'(8'hFF - i)};
    end
    check("l3_wr", DW'(write_o), DW'(1));
    check("l3_line", data_o, exp_line);
    repeat (3) @(negedge clk);
    data_i  = 8'h5C;
    valid_i = 1'b1;
    ack_i   = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    ack_i   = 1'b0;
    exp_line = {exp_line[DW-9:0], 8'h5C};
    check("l3_ack_wr", DW'(write_o), '0);
    check("l3_ack_cnt", DW'(byte_cnt_o), DW'(1));
    check("l3_ack_line", data_o, exp_line);
    check("l3_ack_ovf", DW'(overflow_o), '0);
    check("l3_lines", DW'(lines_o), DW'(1));

    // 5-byte partial line left idle
    pulse_rst();
    tmo_seen = 0;
    for (int i = 0; i < 5; i++) send(8'(i + 1), 0);
    repeat (200) @(negedge clk);
`ifdef DATA_ASSEMBLER_TIMEOUT_EN
    check("idle_cnt", DW'(byte_cnt_o), '0);
    check("idle_tmo", DW'(tmo_seen), DW'(1));
    check("idle_data", data_o, '0);
`else
    check("idle_cnt", DW'(byte_cnt_o), DW'(5));
    check("idle_tmo", DW'(tmo_seen), '0);
    check("idle_data", data_o, DW'(40'h0102030405));
`endif
    check("idle_wr", DW'(write_o), '0);
    check("idle_lines", DW'(lines_o), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
